// File: rtl/decode_issue_ctrl_pkg.sv
// Shared definitions for the decode/issue controller: register address width,
// register count, controller state encodings and small bit-vector helpers.
// Optional feature macro used by this slice: DECODE_WB_BYPASS_EN.
package decode_issue_ctrl_pkg;

  localparam int REG_ADDR = 5;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 6;

  typedef logic [REG_ADDR-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0] reg_vec_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    FLUSH   = 2'd2
  } ctrl_state_e;

  function automatic logic [CNT_W-1:0] popcount(input reg_vec_t v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  function automatic reg_vec_t onehot(input reg_addr_t a);
    return reg_vec_t'(1) << a;
  endfunction

endpackage

// File: rtl/decode_issue_ctrl_issue_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// writer issues, cleared when writeback retires it. Register 0 never pends.
// The count is registered from the next-state vector so it tracks the vector
// exactly after every edge.
module issue_scoreboard
  import decode_issue_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  reg_addr_t        set_addr,
  input  logic             clr_en,
  input  reg_addr_t        clr_addr,
  output reg_vec_t         pending,
  output logic [CNT_W-1:0] pending_cnt
);

  reg_vec_t pending_nxt;

  // Next vector: clear first, then set, so a same-cycle set wins.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) begin
      pending_nxt[clr_addr] = 1'b0;
    end
    if (set_en) begin
      pending_nxt[set_addr] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // Pending vector and its population count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      pending     <= pending_nxt;
      pending_cnt <= popcount(pending_nxt);
    end
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue controller: RAW/WAW hazard detection against a pending
// write scoreboard, plus a branch shadow FSM that blocks issue until the
// branch resolves and emits a one-cycle flush on a taken branch.
// Optional feature: DECODE_WB_BYPASS_EN lets a register being retired this
// cycle count as ready for the hazard check (write-through register file).
//
// state   | meaning
// --------+------------------------------------------------------------
// RUN     | normal issue
// BR_WAIT | branch issued, waiting for M-stage resolve; nothing issues
// FLUSH   | taken branch resolved; flush wrong-path work for one cycle
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  reg_addr_t        dec_src1,
  input  reg_addr_t        dec_src2,
  input  logic             dec_src1_used,
  input  logic             dec_src2_used,
  input  reg_addr_t        dec_dest,
  input  logic             dec_regwrite,
  input  logic             dec_branch,
  input  logic             ex_ready,
  input  logic             wb_valid,
  input  reg_addr_t        wb_dest,
  input  logic             br_resolve,
  input  logic             br_taken,
  output logic             issue,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] pending_cnt
);

  ctrl_state_e state, state_nxt;
  reg_vec_t    pending;
  reg_vec_t    hazard_view;
  logic        hazard;

`ifdef DECODE_WB_BYPASS_EN
  // A register retiring this cycle is already readable through the RF.
  assign hazard_view = pending & ~(wb_valid ? onehot(wb_dest) : '0);
`else
  // Only the registered scoreboard is consulted; no wb_* to issue path.
  assign hazard_view = pending;
`endif

  // RAW on either used source, WAW on the destination.
  assign hazard = (dec_src1_used & hazard_view[dec_src1])
                | (dec_src2_used & hazard_view[dec_src2])
                | (dec_regwrite  & hazard_view[dec_dest]);

  issue_scoreboard u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .set_en      (issue & dec_regwrite),
    .set_addr    (dec_dest),
    .clr_en      (wb_valid),
    .clr_addr    (wb_dest),
    .pending     (pending),
    .pending_cnt (pending_cnt)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and issue/stall/flush decode.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    stall     = 1'b1;
    flush     = 1'b0;
    unique case (state)
      RUN: begin
        issue = dec_valid & ex_ready & ~hazard;
        stall = dec_valid & ~issue;
        if (issue && dec_branch) begin
          state_nxt = BR_WAIT;
        end
      end
      BR_WAIT: begin
        if (br_resolve) begin
          state_nxt = br_taken ? FLUSH : RUN;
        end
      end
      FLUSH: begin
        flush     = 1'b1;
        state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: directed scenarios followed by random traffic,
// all checked against a behavioural model of the issue rules.
module tb_decode_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid, dec_src1_used, dec_src2_used, dec_regwrite, dec_branch;
  logic [4:0] dec_src1, dec_src2, dec_dest, wb_dest;
  logic       ex_ready, wb_valid, br_resolve, br_taken;
  logic       issue, stall, flush;
  logic [5:0] pending_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Model: set of registers awaiting writeback, and where the controller is.
  bit m_pend[32];
  int m_mode;   // 0 normal, 1 waiting on branch, 2 flushing
  bit m_issue_last;

  always #5 clk = ~clk;

  decode_issue_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .dec_valid     (dec_valid),
    .dec_src1      (dec_src1),
    .dec_src2      (dec_src2),
    .dec_src1_used (dec_src1_used),
    .dec_src2_used (dec_src2_used),
    .dec_dest      (dec_dest),
    .dec_regwrite  (dec_regwrite),
    .dec_branch    (dec_branch),
    .ex_ready      (ex_ready),
    .wb_valid      (wb_valid),
    .wb_dest       (wb_dest),
    .br_resolve    (br_resolve),
    .br_taken      (br_taken),
    .issue         (issue),
    .stall         (stall),
    .flush         (flush),
    .pending_cnt   (pending_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 1; i < 32; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_mode = 0;
  endtask

  task automatic idle();
    dec_valid = 0; dec_src1 = 0; dec_src2 = 0; dec_src1_used = 0; dec_src2_used = 0;
    dec_dest = 0; dec_regwrite = 0; dec_branch = 0; ex_ready = 1;
    wb_valid = 0; wb_dest = 0; br_resolve = 0; br_taken = 0;
  endtask

  task automatic instr(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                       input int d, input bit rw, input bit br);
    dec_valid = v; dec_src1 = 5'(s1); dec_src1_used = u1; dec_src2 = 5'(s2);
    dec_src2_used = u2; dec_dest = 5'(d); dec_regwrite = rw; dec_branch = br;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string tag);
    bit busy[32];
    bit haz, e_issue, e_stall, e_flush;
    #1;
    for (int i = 0; i < 32; i++) busy[i] = m_pend[i];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_valid) busy[wb_dest] = 1'b0;
`endif
    haz = (dec_src1_used && busy[dec_src1]) || (dec_src2_used && busy[dec_src2]) ||
          (dec_regwrite && busy[dec_dest]);
    e_issue = dec_valid && ex_ready && !haz && (m_mode == 0);
    e_stall = (dec_valid && !e_issue) || (m_mode != 0);
    e_flush = (m_mode == 2);
    chk({tag, ".issue"}, 32'(issue), 32'(e_issue));
    chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
    chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
    m_issue_last = e_issue;
    @(posedge clk);
    if (wb_valid) m_pend[wb_dest] = 1'b0;
    if (e_issue && dec_regwrite && dec_dest != 0) m_pend[dec_dest] = 1'b1;
    case (m_mode)
      0: if (e_issue && dec_branch) m_mode = 1;
      1: if (br_resolve) m_mode = br_taken ? 2 : 0;
      default: m_mode = 0;
    endcase
    #1;
    chk({tag, ".cnt"}, 32'(pending_cnt), 32'(model_count()));
    @(negedge clk);
  endtask

  initial begin
    int q[$];
    idle();
    model_reset();
    reset = 0;
    repeat (3) @(negedge clk);
    chk("rst.cnt", 32'(pending_cnt), 0);
    chk("rst.flush", 32'(flush), 0);
    chk("rst.stall", 32'(stall), 0);
    reset = 1;
    @(negedge clk);

    // RAW on r5, released by writeback.
    instr(1, 0, 0, 0, 0, 5, 1, 0); step("raw.wr");
    instr(1, 5, 1, 0, 0, 0, 0, 0); step("raw.blocked");
    wb_valid = 1; wb_dest = 5;     step("raw.wb");
`ifdef DECODE_WB_BYPASS_EN
    chk("raw.bypass_issue", 32'(m_issue_last), 1);
`else
    chk("raw.nobypass_hold", 32'(m_issue_last), 0);
`endif
    wb_valid = 0;                  step("raw.after");
    idle();                        step("raw.idle");

    // WAW on r7, and set/clear collision on r7.
    instr(1, 0, 0, 0, 0, 7, 1, 0); step("waw.wr1");
    instr(1, 0, 0, 0, 0, 7, 1, 0); step("waw.wr2");
    wb_valid = 1; wb_dest = 7;     step("waw.wb_reissue");
    wb_valid = 0;
    if (m_pend[7] == 0) begin      // r7 free now: set and clear in one cycle
      wb_valid = 1; wb_dest = 7;   step("waw.collide");
      wb_valid = 0;
    end
    chk("waw.r7_pending_cnt", 32'(pending_cnt), 1);
    idle(); wb_valid = 1; wb_dest = 7; step("waw.retire");
    wb_valid = 1; wb_dest = 9;     step("waw.retire_free");
    idle();

    // Ten writers of r0 never pend.
    for (int i = 0; i < 10; i++) begin
      instr(1, 0, 0, 0, 0, 0, 1, 0); step("r0.wr");
    end
    chk("r0.cnt", 32'(pending_cnt), 0);
    idle();

    // Taken branch; stray resolve in normal operation is ignored.
    br_resolve = 1; br_taken = 1;  step("br.stray");
    br_resolve = 0; br_taken = 0;
    instr(1, 0, 0, 0, 0, 0, 0, 1); step("br.issue");
    instr(1, 0, 0, 0, 0, 3, 1, 0); step("br.wait");
    br_resolve = 1; br_taken = 1;  step("br.resolve_t");
    br_resolve = 0; br_taken = 0;  step("br.flush");
    step("br.run");
    idle();
    instr(1, 0, 0, 0, 0, 0, 0, 1); step("brn.issue");
    idle(); br_resolve = 1;        step("brn.resolve_nt");
    br_resolve = 0; instr(1, 0, 0, 0, 0, 0, 0, 0); step("brn.run");
    idle(); wb_valid = 1; wb_dest = 3; step("br.clean");
    idle();

    // Fill every register, then retire them all.
    for (int r = 1; r < 32; r++) begin
      instr(1, 0, 0, 0, 0, r, 1, 0); step("cap.fill");
    end
    chk("cap.full", 32'(pending_cnt), 31);
    idle();
    for (int r = 1; r < 32; r++) begin
      wb_valid = 1; wb_dest = 5'(r); step("cap.drain");
    end
    chk("cap.empty", 32'(pending_cnt), 0);
    idle();

    // Reset while waiting on a branch with four registers pending.
    for (int r = 1; r < 5; r++) begin
      instr(1, 0, 0, 0, 0, r, 1, 0); step("mid.fill");
    end
    instr(1, 0, 0, 0, 0, 0, 0, 1); step("mid.branch");
    idle(); step("mid.wait");
    reset = 0;
    model_reset();
    #1;
    chk("mid.cnt", 32'(pending_cnt), 0);
    chk("mid.flush", 32'(flush), 0);
    chk("mid.stall", 32'(stall), 0);
    @(negedge clk);
    reset = 1;
    instr(1, 1, 1, 2, 1, 3, 1, 0); step("mid.indep");
    chk("mid.indep_issue", 32'(m_issue_last), 1);
    idle(); wb_valid = 1; wb_dest = 3; step("mid.clean");
    idle();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      instr($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 7) == 0);
      ex_ready = $urandom_range(0, 3) != 0;
      q.delete();
      for (int i = 1; i < 32; i++) if (m_pend[i]) q.push_back(i);
      wb_valid = $urandom_range(0, 1);
      if (q.size() != 0 && $urandom_range(0, 3) != 0)
        wb_dest = 5'(q[$urandom_range(0, q.size() - 1)]);
      else
        wb_dest = 5'($urandom_range(0, 7));
      br_resolve = $urandom_range(0, 2) == 0;
      br_taken = $urandom_range(0, 1);
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_issue_ctrl.md
DECODE_ISSUE_CTRL -- requirements
Module: decode_issue_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are named clk and reset as elsewhere in the pipeline.
REQ-002 clk  in  1  stage clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; clears all state.
REQ-004 dec_valid  in  1  decode holds a valid instruction.
REQ-005 dec_src1, dec_src2  in  REG_ADDR  source register addresses from decode.
REQ-006 dec_src1_used, dec_src2_used  in  1  the matching source is actually read.
REQ-007 dec_dest  in  REG_ADDR  destination register of the decoded instruction.
REQ-008 dec_regwrite  in  1  instruction writes dec_dest.
REQ-009 dec_branch  in  1  instruction is a branch or jump.
REQ-010 ex_ready  in  1  EX stage accepts an instruction this cycle.
REQ-011 wb_valid  in  1  writeback retires a register write this cycle.
REQ-012 wb_dest  in  REG_ADDR  register retired by writeback.
REQ-013 br_resolve, br_taken  in  1 each  M-stage branch outcome strobe and direction.
REQ-014 issue  out  1  decode instruction is passed to EX this cycle.
REQ-015 stall  out  1  decode and fetch must hold.
REQ-016 flush  out  1  kill wrong-path instructions in fetch and decode.
REQ-017 pending_cnt  out  6  number of registers with an outstanding write.

Function
REQ-018 The block SHALL keep a 32-bit pending vector, one bit per register; register 0 is never marked pending.
REQ-019 A hazard SHALL exist when a used source, or dec_dest with dec_regwrite=1, has its pending bit set (RAW and WAW).
REQ-020 issue SHALL be combinational: dec_valid & ex_ready & ~hazard & (state==RUN).
REQ-021 stall SHALL equal (dec_valid & ~issue) | (state!=RUN).
REQ-022 On issue with dec_regwrite=1 and dec_dest!=0, the pending bit for dec_dest SHALL be set at the next edge.
REQ-023 On wb_valid, the pending bit for wb_dest SHALL be cleared at the next edge; wb_valid on a non-pending register SHALL have no effect.
REQ-024 If a set and a clear target the same register in the same cycle, the set SHALL win.
REQ-025 pending_cnt SHALL be registered and equal the popcount of the pending vector after each edge; range 0..31.
REQ-026 The FSM SHALL have three states: RUN, BR_WAIT, FLUSH.
REQ-027 RUN -> BR_WAIT on issue with dec_branch=1; otherwise remain in RUN.
REQ-028 BR_WAIT: no issue; on br_resolve with br_taken=1 go to FLUSH; with br_taken=0 go to RUN.
REQ-029 FLUSH SHALL last exactly one cycle with flush=1, then go to RUN; flush SHALL be 0 in all other states.
REQ-030 br_resolve SHALL be ignored outside BR_WAIT.
REQ-031 Issue-to-scoreboard latency SHALL be 1 cycle; there is no combinational path from wb_* to issue unless REQ-035 applies.

Reset
REQ-032 While reset=0: pending vector = 0, state = RUN, pending_cnt = 0, flush = 0.
REQ-033 A reset asserted mid-operation, including in BR_WAIT or FLUSH, SHALL drop all pending state immediately without producing a flush pulse.

Configuration
REQ-034 The macro DECODE_WB_BYPASS_EN SHALL select writeback bypass.
REQ-035 With DECODE_WB_BYPASS_EN defined, a register being cleared by wb_valid/wb_dest in the current cycle SHALL count as not pending for the hazard check, so the dependent instruction issues in the same cycle (write-through register file).
REQ-036 Without DECODE_WB_BYPASS_EN, the hazard check SHALL use only the registered pending vector, so a dependent instruction issues one cycle after writeback.

Structure
REQ-037 REG_ADDR, the FSM state encodings (RUN=2'd0, BR_WAIT=2'd1, FLUSH=2'd2) and the register count SHALL live in the shared define file.
REQ-038 The pending vector, its set/clear logic and the popcount SHALL be one sub-module, issue_scoreboard; the FSM and issue logic stay in decode_issue_ctrl.

Verification
REQ-039 RAW stall: issue r5 writer; next cycle, reader of r5 with wb idle -> issue=0, stall=1; wb_valid with wb_dest=5 -> reader issues in the same cycle with the bypass macro defined, or one cycle later without it.
REQ-040 WAW plus simultaneous set/clear: r7 is pending; a new writer of r7 stalls; wb_dest=7 and a re-issue of r7 in the same cycle -> r7 remains pending and pending_cnt is unchanged.
REQ-041 Register 0: 10 back-to-back writers of r0 -> all issue, pending_cnt stays 0.
REQ-042 Taken branch: issue a branch -> BR_WAIT with issue=0; br_resolve=1, br_taken=1 -> flush=1 for exactly one cycle, then RUN; the not-taken case returns to RUN with no flush.
REQ-043 Capacity: fill r1..r31 -> pending_cnt=31; retire all -> pending_cnt=0.
REQ-044 Reset mid-operation: reset=0 while in BR_WAIT with 4 registers pending -> state RUN, pending_cnt=0, flush=0, and the next independent instruction issues.
